// File: rtl/cpu_ext_pkg.sv
// Shared immediate-extension op codes and the pure extension function used by
// decode, branch, jump and the immediate-generation unit.
package cpu_ext_pkg;

   localparam int EXT_DATA_W  = 32;
   localparam int EXT_IMM_W   = 16;
   localparam int EXT_TGT_W   = 26;
   localparam int EXT_PC_HI_W = EXT_DATA_W - EXT_TGT_W - 2;

   typedef enum logic [2:0] {
      EXTOP_UNSIGNED = 3'b000,
      EXTOP_SIGNED   = 3'b001,
      EXTOP_INST     = 3'b010,
      EXTOP_LUI      = 3'b011,
      EXTOP_BRANCH   = 3'b100,
      EXTOP_JUMP     = 3'b101,
      EXTOP_ILL_A    = 3'b110,
      EXTOP_ILL_B    = 3'b111
   } ext_op_e;

   typedef logic [EXT_DATA_W:0] ext_res_t;

   // Returns {err, result}; illegal ops produce a zero result with err set.
   function automatic ext_res_t ext_imm(
      input logic [2:0]             op,
      input logic [EXT_TGT_W-1:0]   field,
      input logic [EXT_PC_HI_W-1:0] pc_hi
   );
      logic [EXT_IMM_W-1:0]  s;
      logic [EXT_DATA_W-1:0] sext;
      logic [EXT_DATA_W-1:0] res;
      logic                  err;
      s    = field[EXT_IMM_W-1:0];
      sext = {{(EXT_DATA_W-EXT_IMM_W){s[EXT_IMM_W-1]}}, s};
      res  = '0;
      err  = 1'b0;
      case (op)
         EXTOP_UNSIGNED: res = {{(EXT_DATA_W-EXT_IMM_W){1'b0}}, s};
         EXTOP_SIGNED:   res = sext;
         EXTOP_INST:     res = '0;
         EXTOP_LUI:      res = {s, {(EXT_DATA_W-EXT_IMM_W){1'b0}}};
         EXTOP_BRANCH:   res = {sext[EXT_DATA_W-3:0], 2'b00};
         EXTOP_JUMP:     res = {pc_hi, field, 2'b00};
         default: begin
            res = '0;
            err = 1'b1;
         end
      endcase
      return {err, res};
   endfunction

endpackage

// File: rtl/imm_ext_fifo.sv
// Synchronous FIFO with occupancy count; pushes into a full queue are dropped
// even when a pop happens in the same cycle. Empty head reads as zero.
module imm_ext_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = cnt;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage carries no reset; validity is tracked by cnt alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/imm_ext_unit.sv
// Registered immediate generator: extends the instruction immediate per ext_op
// and queues {err, imm} results so decode can run ahead of execute.
module imm_ext_unit
   import cpu_ext_pkg::*;
#(
   parameter int DATA_W = EXT_DATA_W,
   parameter int IMM_W  = EXT_IMM_W,
   parameter int TGT_W  = EXT_TGT_W,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [TGT_W-1:0]           imm_field,
   input  logic [DATA_W-TGT_W-3:0]    pc_hi,
   input  logic [2:0]                 ext_op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          imm_out,
   output logic                       op_err,
   output logic [$clog2(DEPTH):0]     q_count
);

   // The extension function is sized by the shared package widths.
   ext_res_t          ext_res;
   logic [DATA_W:0]   head;
   logic              full;
   logic              empty;
   logic              accept;
   logic              pop;

   assign ext_res   = ext_imm(ext_op, imm_field, pc_hi);
   assign in_ready  = rst_n & ~full;
   assign accept    = in_valid & in_ready;
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;

   imm_ext_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .din   (ext_res),
      .pop   (pop),
      .dout  (head),
      .count (q_count),
      .full  (full),
      .empty (empty)
   );

   assign op_err  = head[DATA_W];
   assign imm_out = head[DATA_W-1:0];

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed vector table plus handshake, reset and random-stream sequences for imm_ext_unit.
module tb_imm_ext_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [25:0] imm_field;
   logic [3:0]  pc_hi;
   logic [2:0]  ext_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] imm_out;
   logic        op_err;
   logic [1:0]  q_count;

   int n_chk  = 0;
   int n_fail = 0;

   imm_ext_unit #(.DATA_W(32), .IMM_W(16), .TGT_W(26), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm_field (imm_field),
      .pc_hi     (pc_hi),
      .ext_op    (ext_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imm_out   (imm_out),
      .op_err    (op_err),
      .q_count   (q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [25:0] field;
      logic [3:0]  pc;
      logic [31:0] imm;
      logic        err;
   } vec_t;

   vec_t vecs[13];

   task automatic drive(input logic [2:0] op, input logic [25:0] f, input logic [3:0] pc);
      ext_op    = op;
      imm_field = f;
      pc_hi     = pc;
   endtask

   initial begin
      logic [31:0] mq[$];
      int sent;
      int recvd;
      logic acc;
      logic pp;
      logic [25:0] rf;

      vecs[0]  = '{3'b000, 26'h0008001, 4'h0, 32'h00008001, 1'b0};
      vecs[1]  = '{3'b001, 26'h0008001, 4'h0, 32'hFFFF8001, 1'b0};
      vecs[2]  = '{3'b011, 26'h0001234, 4'h0, 32'h12340000, 1'b0};
      vecs[3]  = '{3'b100, 26'h000FFFF, 4'h0, 32'hFFFFFFFC, 1'b0};
      vecs[4]  = '{3'b101, 26'h0000010, 4'hA, 32'hA0000040, 1'b0};
      vecs[5]  = '{3'b010, 26'h3FFFFFF, 4'hF, 32'h00000000, 1'b0};
      vecs[6]  = '{3'b110, 26'h000FFFF, 4'h0, 32'h00000000, 1'b1};
      vecs[7]  = '{3'b111, 26'h0001234, 4'h5, 32'h00000000, 1'b1};
      vecs[8]  = '{3'b001, 26'h0007FFF, 4'h0, 32'h00007FFF, 1'b0};
      vecs[9]  = '{3'b100, 26'h0008000, 4'h0, 32'hFFFE0000, 1'b0};
      vecs[10] = '{3'b000, 26'h3FF0005, 4'h0, 32'h00000005, 1'b0};
      vecs[11] = '{3'b011, 26'h3C0FFFF, 4'h0, 32'hFFFF0000, 1'b0};
      vecs[12] = '{3'b101, 26'h3FFFFFF, 4'hF, 32'hFFFFFFFC, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drive(3'b000, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_q_count", 64'(q_count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_imm_out", 64'(imm_out), 64'd0);
      chk("rst_op_err", 64'(op_err), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Table: one push, check head one cycle later, then pop.
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].op, vecs[i].field, vecs[i].pc);
         in_valid  = 1'b1;
         out_ready = 1'b0;
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_imm", i), 64'(imm_out), 64'(vecs[i].imm));
         chk($sformatf("vec%0d_err", i), 64'(op_err), 64'(vecs[i].err));
         chk($sformatf("vec%0d_cnt", i), 64'(q_count), 64'd1);
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready = 1'b0;
         chk($sformatf("vec%0d_empty", i), 64'(out_valid), 64'd0);
      end
      chk("empty_imm_zero", 64'(imm_out), 64'd0);

      // Backpressure and full-queue push+pop.
      out_ready = 1'b0;
      drive(3'b011, 26'h0001111, 4'h0); in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      drive(3'b011, 26'h0002222, 4'h0);
      @(posedge clk); @(negedge clk);
      drive(3'b011, 26'h0003333, 4'h0);
      #1;
      chk("bp_full_in_ready", 64'(in_ready), 64'd0);
      chk("bp_full_cnt", 64'(q_count), 64'd2);
      @(posedge clk); @(negedge clk);
      chk("bp_refused_cnt", 64'(q_count), 64'd2);
      chk("bp_head_a", 64'(imm_out), 64'h11110000);
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("full_pushpop_cnt", 64'(q_count), 64'd1);
      chk("bp_head_b", 64'(imm_out), 64'h22220000);
      chk("bp_in_ready_back", 64'(in_ready), 64'd1);
      @(posedge clk); @(negedge clk);
      chk("pushpop_cnt_same", 64'(q_count), 64'd1);
      chk("bp_head_c", 64'(imm_out), 64'h33330000);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("bp_drained", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // Illegal op followed by a legal one, queued back-to-back.
      drive(3'b110, 26'h000FFFF, 4'h0); in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      drive(3'b001, 26'h000FFFF, 4'h0);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk("ill_imm", 64'(imm_out), 64'd0);
      chk("ill_err", 64'(op_err), 64'd1);
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      chk("after_ill_imm", 64'(imm_out), 64'hFFFFFFFF);
      chk("after_ill_err", 64'(op_err), 64'd0);
      drive(3'b000, 26'h0000777, 4'h0); in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_cnt", 64'(q_count), 64'd2);

      // Reset with a full queue.
      rst_n = 1'b0;
      #1 chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); @(negedge clk);
      chk("rst_mid_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_cnt", 64'(q_count), 64'd0);
      chk("rst_mid_imm", 64'(imm_out), 64'd0);
      chk("rst_mid_err", 64'(op_err), 64'd0);
      rst_n = 1'b1;

      // Random stream against a queue model; exercises pointer wrap.
      sent  = 0;
      recvd = 0;
      for (int cyc = 0; cyc < 200 && recvd < 10; cyc++) begin
         rf        = 26'($urandom);
         in_valid  = (sent < 10);
         drive(3'b001, rf, 4'h0);
         out_ready = 1'($urandom_range(0, 1));
         #1;
         chk("rnd_cnt", 64'(q_count), 64'(mq.size()));
         chk("rnd_valid", 64'(out_valid), 64'(mq.size() != 0));
         chk("rnd_in_ready", 64'(in_ready), 64'(mq.size() < 2));
         if (mq.size() != 0) chk("rnd_imm", 64'(imm_out), 64'(mq[0]));
         acc = in_valid && (mq.size() < 2);
         pp  = out_ready && (mq.size() != 0);
         @(posedge clk);
         if (pp) begin
            void'(mq.pop_front());
            recvd++;
         end
         if (acc) begin
            mq.push_back({{16{rf[15]}}, rf[15:0]});
            sent++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("rnd_all_received", 64'(recvd), 64'd10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
